// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    seq_divider_if.slave bus
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVIDEND_W-1:0] quot_sh;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W:0]    prem;
    logic [CNT_W-1:0]      count;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  dbz_q;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;
    logic [DIVIDEND_W-1:0] quot_next;
    logic [DIVISOR_W:0]    prem_next;

    // One extra partial-remainder bit keeps the shifted value exact before the trial subtract.
    always_comb begin
        shifted   = {prem[DIVISOR_W-1:0], dvd_sh[DIVIDEND_W-1]};
        trial     = shifted - {1'b0, dvs};
        fits      = (shifted >= {1'b0, dvs});
        quot_next = {quot_sh[DIVIDEND_W-2:0], fits};
        prem_next = fits ? trial : shifted;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            dvd_sh      <= '0;
            quot_sh     <= '0;
            dvs         <= '0;
            prem        <= '0;
            count       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    dvd_sh  <= dvd_sh << 1;
                    quot_sh <= quot_next;
                    prem    <= prem_next;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        state       <= S_DONE;
                        quotient_q  <= quot_next;
                        remainder_q <= prem_next[DIVISOR_W-1:0];
                    end
                end
                // IDLE and DONE both accept a new request, giving back-to-back operation.
                default: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            state   <= S_RUN;
                            dvd_sh  <= bus.dividend;
                            dvs     <= bus.divisor;
                            prem    <= '0;
                            quot_sh <= '0;
                            count   <= '0;
                            dbz_q   <= 1'b0;
                        end else begin
                            state       <= S_DONE;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider. It is the inverse-operation companion to the team's 4x4 pipelined multiplier.
- Takes an 8-bit dividend and a 4-bit divisor (same operand widths as the multiplier product/operand) and produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so the multiplier's bench can chain multiply -> divide round-trip checks.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the iteration count.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- resetn  input  1  synchronous active-low reset.
- start  input  1  request; accepted only on an edge where busy==0.
- dividend  input  DIVIDEND_W  numerator, sampled on the accepting edge only.
- divisor  input  DIVISOR_W  denominator, sampled on the accepting edge only.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse: results valid.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  high with done when divisor was 0; held with results.

Behaviour:
- Reset: clk, resetn synchronous active-low. While resetn==0 at a posedge: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared. Reset overrides start and aborts any operation in progress; no done is produced for an aborted operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 and divisor!=0 -> latch operands, iteration counter=0, partial remainder (DIVISOR_W+1 bits)=0 -> RUN. start=1 and divisor==0 -> DONE with quotient=all ones, remainder=0, div_by_zero=1.
  - RUN: each cycle shift the partial remainder left, bringing in the next dividend bit (MSB first). Trial-subtract the divisor. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0. Counter increments; after DIVIDEND_W iterations -> DONE.
  - DONE: done=1 for exactly this cycle; quotient/remainder/div_by_zero registered and valid. Next state IDLE, or directly RUN/DONE if start=1 this cycle (back-to-back accepted, since busy==0).
- Latency: start accepted at edge N -> busy high after edges N+1..N+DIVIDEND_W, done high after edge N+DIVIDEND_W+1 (9 cycles for the defaults). Divide-by-zero: done high after edge N+1; busy never asserts.
- start while busy==1 is ignored; operands are not resampled; the running operation is unaffected.
- quotient, remainder, div_by_zero hold their last values until the next accepted start (or reset). A new non-zero-divisor start clears div_by_zero at its accepting edge.
- Arithmetic: unsigned only. remainder < divisor always. quotient*divisor+remainder == dividend exactly, with no truncation, since quotient is DIVIDEND_W bits. The partial remainder needs DIVISOR_W+1 bits so the trial subtraction never overflows.
- Outputs are registered; no combinational path from start/dividend/divisor to any output.

Test Plan:
- Reset, then dividend=200, divisor=7, start 1 cycle -> busy high 8 cycles, done pulse on the 9th cycle, quotient=28, remainder=4, div_by_zero=0.
- 255/15 -> quotient=17, remainder=0. 13/1 -> quotient=13, remainder=0. 5/9 -> quotient=0, remainder=5. 0/3 -> quotient=0, remainder=0.
- 100/0 -> done one cycle after the accepting edge, busy never high, quotient=0xFF, remainder=0, div_by_zero=1. A following 100/10 -> quotient=10, remainder=0, div_by_zero=0.
- Start 200/7. Pulse start with 50/5 at cycle 3 of RUN -> ignored; result still 28 r4; no second done.
- Start 200/7, drop resetn at cycle 4 of RUN for 1 cycle -> all outputs 0, no done. A new 81/9 after reset -> quotient=9, remainder=0.
- Back-to-back: hold start high with 255/15 then 64/8 presented in the DONE cycle -> second op accepted in the DONE cycle, done pulses 9 cycles apart, results 17 r0 then 8 r0.
- Exhaustive: all 256x15 non-zero pairs; checker asserts quotient*divisor+remainder==dividend and remainder<divisor.
